// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sweeps {a,b,c} through 000..111 and captures s1/s2 truth tables
// Optional self-check against expected tables: define TT_SWEEPER_CHECK_EN.
module truth_table_sweeper #(
    parameter int HOLD_CYCLES = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       s1_in,
    input  logic       s2_in,
`ifdef TT_SWEEPER_CHECK_EN
    input  logic [7:0] exp_s1,
    input  logic [7:0] exp_s2,
    output logic       mismatch,
`endif
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic [7:0] tt_s1,
    output logic [7:0] tt_s2
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       tt_s1_q, tt_s1_d;
    logic [7:0]       tt_s2_q, tt_s2_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
            tt_s1_q <= 8'h00;
            tt_s2_q <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tt_s1_q <= tt_s1_d;
            tt_s2_q <= tt_s2_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tt_s1_d = tt_s1_q;
        tt_s2_d = tt_s2_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DRIVE;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                    tt_s1_d = 8'h00;
                    tt_s2_d = 8'h00;
                end
            end
            ST_DRIVE: begin
                // Sample on the last edge of the hold window, then advance the vector.
                if (cnt_q == CNT_LAST) begin
                    tt_s1_d[idx_q] = s1_in;
                    tt_s2_d[idx_q] = s2_in;
                    cnt_d          = '0;
                    if (idx_q == 3'd7) begin
                        state_d = ST_DONE;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 3'd0;
                cnt_d   = '0;
            end
        endcase
    end

    assign {a, b, c} = idx_q;
    assign busy      = (state_q == ST_DRIVE);
    assign done      = (state_q == ST_DONE);
    assign tt_s1     = tt_s1_q;
    assign tt_s2     = tt_s2_q;

`ifdef TT_SWEEPER_CHECK_EN
    logic [7:0] exp_s1_q;
    logic [7:0] exp_s2_q;
    logic       mismatch_q;
    logic       start_acc;
    logic       sample;

    assign start_acc = (state_q == ST_IDLE) && start;
    assign sample    = (state_q == ST_DRIVE) && (cnt_q == CNT_LAST);

    // Expected tables are latched at start so they may change freely during the sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_s1_q   <= 8'h00;
            exp_s2_q   <= 8'h00;
            mismatch_q <= 1'b0;
        end else if (start_acc) begin
            exp_s1_q   <= exp_s1;
            exp_s2_q   <= exp_s2;
            mismatch_q <= 1'b0;
        end else if (sample &&
                     ((s1_in != exp_s1_q[idx_q]) || (s2_in != exp_s2_q[idx_q]))) begin
            mismatch_q <= 1'b1;
        end
    end

    assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - directed self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;

    localparam int HOLD = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic       s1_in;
    logic       s2_in;
    logic       a;
    logic       b;
    logic       c;
    logic       busy;
    logic       done;
    logic [7:0] tt_s1;
    logic [7:0] tt_s2;
`ifdef TT_SWEEPER_CHECK_EN
    logic [7:0] exp_s1;
    logic [7:0] exp_s2;
    logic       mismatch;
`endif

    int errors = 0;
    int checks = 0;
    int n;

    truth_table_sweeper #(.HOLD_CYCLES(HOLD)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .s1_in (s1_in),
        .s2_in (s2_in),
`ifdef TT_SWEEPER_CHECK_EN
        .exp_s1   (exp_s1),
        .exp_s2   (exp_s2),
        .mismatch (mismatch),
`endif
        .a     (a),
        .b     (b),
        .c     (c),
        .busy  (busy),
        .done  (done),
        .tt_s1 (tt_s1),
        .tt_s2 (tt_s2)
    );

    // Zero-latency model of the unit under test.
    assign s1_in = a & b;
    assign s2_in = a ^ b ^ c;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (done !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
        if (done !== 1'b1) cnt = -1;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
`ifdef TT_SWEEPER_CHECK_EN
        exp_s1 = 8'hC0;
        exp_s2 = 8'h96;
`endif
        // Reset with start held high
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_abc", {a, b, c}, 0);
            chk("rst_tt_s1", tt_s1, 8'h00);
            chk("rst_tt_s2", tt_s2, 8'h00);
        end
        rst   = 1'b0;
        start = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // Basic sweep: each vector held HOLD cycles, in order
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int v = 0; v < 8; v++) begin
            for (int h = 0; h < HOLD; h++) begin
                chk("sweep_abc", {a, b, c}, v);
                chk("sweep_busy", busy, 1);
                chk("sweep_done", done, 0);
                tick();
            end
        end
        chk("basic_done", done, 1);
        chk("basic_busy_at_done", busy, 0);
        chk("basic_abc_at_done", {a, b, c}, 0);
        chk("basic_tt_s1", tt_s1, 8'hC0);
        chk("basic_tt_s2", tt_s2, 8'h96);
`ifdef TT_SWEEPER_CHECK_EN
        chk("basic_mismatch", mismatch, 0);
`endif
        tick();
        chk("basic_done_once", done, 0);
        chk("basic_idle_busy", busy, 0);
        chk("basic_tt_hold", tt_s1, 8'hC0);

        // Start pulsed during vector 3 is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (12) tick();
        chk("ign_abc_v3", {a, b, c}, 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        chk("ign_cycles_to_done", n, 19);
        chk("ign_tt_s1", tt_s1, 8'hC0);
        chk("ign_tt_s2", tt_s2, 8'h96);
        tick();
        chk("ign_done_once", done, 0);
        chk("ign_idle_busy", busy, 0);

        // Reset during vector 5
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        chk("mid_abc_v5", {a, b, c}, 5);
        chk("mid_partial_tt_s2", tt_s2, 8'h16);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_abc", {a, b, c}, 0);
        chk("mid_rst_tt_s1", tt_s1, 8'h00);
        chk("mid_rst_tt_s2", tt_s2, 8'h00);
        tick();
        chk("mid_no_done", done, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        chk("mid_resweep_cycles", n, 32);
        chk("mid_resweep_tt_s1", tt_s1, 8'hC0);
        chk("mid_resweep_tt_s2", tt_s2, 8'h96);
        tick();

        // Back-to-back with start held high
        start = 1'b1;
        tick();
        chk("b2b_busy", busy, 1);
        wait_done(n);
        chk("b2b_cycles1", n, 32);
        chk("b2b_tt_s2_1", tt_s2, 8'h96);
        tick();
        chk("b2b_idle_busy", busy, 0);
        chk("b2b_idle_done", done, 0);
        chk("b2b_idle_tt_s1", tt_s1, 8'hC0);
        tick();
        chk("b2b_restart_busy", busy, 1);
        chk("b2b_cleared_tt_s1", tt_s1, 8'h00);
        chk("b2b_cleared_tt_s2", tt_s2, 8'h00);
        start = 1'b0;
        wait_done(n);
        chk("b2b_cycles2", n, 32);
        chk("b2b_tt_s1_2", tt_s1, 8'hC0);
        chk("b2b_tt_s2_2", tt_s2, 8'h96);
        tick();

`ifdef TT_SWEEPER_CHECK_EN
        // Wrong expected s2 bit 0 trips mismatch at the vector-0 sample edge
        exp_s2 = 8'h97;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        exp_s2 = 8'h96;
        chk("mis_cleared", mismatch, 0);
        repeat (HOLD - 1) tick();
        chk("mis_before_sample", mismatch, 0);
        tick();
        chk("mis_after_sample", mismatch, 1);
        wait_done(n);
        chk("mis_at_done", mismatch, 1);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
